// File: rtl/fisc_mem_pkg.sv
// Shared types for the FISC dual-channel memory responder.
package fisc_mem_pkg;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_ADDR_W = 16;

    // One captured request: write flag, word address and write data.
    typedef struct packed {
        logic                  wr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    typedef enum logic {CH_IDLE, CH_PEND} ch_state_t;
    typedef enum logic {CHAN_A, CHAN_B} chan_t;

    // The channel that gets priority after the given one wins a conflict.
    function automatic chan_t other_chan(input chan_t c);
        return (c == CHAN_A) ? CHAN_B : CHAN_A;
    endfunction

endpackage

// File: rtl/fisc_mem_req_port.sv
// Per-channel request capture: latches one request and holds it until granted.
module fisc_mem_req_port
    import fisc_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_rd,
    input  logic                  i_wr,
    input  logic [MEM_ADDR_W-1:0] i_addr,
    input  logic [MEM_DATA_W-1:0] i_data,
    input  logic                  i_grant,
    output logic                  o_pend,
    output mem_req_t              o_req
);

    ch_state_t r_state;
    mem_req_t  r_req;

    // Capture FSM; inputs are ignored while a request is pending, and rd+wr
    // together is taken as a write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= CH_IDLE;
            r_req   <= '0;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (i_rd || i_wr) begin
                        r_req.wr   <= i_wr;
                        r_req.addr <= i_addr;
                        r_req.data <= i_data;
                        r_state    <= CH_PEND;
                    end
                end
                CH_PEND: begin
                    if (i_grant)
                        r_state <= CH_IDLE;
                end
                default: r_state <= CH_IDLE;
            endcase
        end
    end

    assign o_pend = (r_state == CH_PEND);
    assign o_req  = r_req;

endmodule

// File: rtl/fisc_mem_responder.sv
// Dual-channel memory responder: two capture ports arbitrated onto one
// single-port word array, one access per cycle.
module fisc_mem_responder
    import fisc_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_rd_a,
    input  logic              i_wr_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_din_a,
    output logic [DATA_W-1:0] o_dout_a,
    output logic              o_ack_a,
    output logic              o_err_a,
    input  logic              i_rd_b,
    input  logic              i_wr_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_din_b,
    output logic [DATA_W-1:0] o_dout_b,
    output logic              o_ack_b,
    output logic              o_err_b
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              w_pend_a, w_pend_b;
    logic              w_gnt_a, w_gnt_b;
    mem_req_t          w_req_a, w_req_b, w_sel;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rdata;

    chan_t             r_prio;
    logic [DATA_W-1:0] r_dout_a, r_dout_b;
    logic              r_ack_a, r_ack_b, r_err_a, r_err_b;
    logic [DATA_W-1:0] r_mem [DEPTH];

    fisc_mem_req_port u_port_a (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rd    (i_rd_a),
        .i_wr    (i_wr_a),
        .i_addr  (i_addr_a),
        .i_data  (i_din_a),
        .i_grant (w_gnt_a),
        .o_pend  (w_pend_a),
        .o_req   (w_req_a)
    );

    fisc_mem_req_port u_port_b (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rd    (i_rd_b),
        .i_wr    (i_wr_b),
        .i_addr  (i_addr_b),
        .i_data  (i_din_b),
        .i_grant (w_gnt_b),
        .o_pend  (w_pend_b),
        .o_req   (w_req_b)
    );

    // A lone pending channel always wins; a conflict goes to r_prio.
    assign w_gnt_a = w_pend_a && (!w_pend_b || (r_prio == CHAN_A));
    assign w_gnt_b = w_pend_b && (!w_pend_a || (r_prio == CHAN_B));

    assign w_sel      = w_gnt_a ? w_req_a : w_req_b;
    assign w_in_range = ({1'b0, w_sel.addr} < DEPTH_L);
    assign w_idx      = w_sel.addr[IDX_W-1:0];
    assign w_rdata    = w_in_range ? r_mem[w_idx] : '0;

    // Array write port; not reset, and a low reset_n suppresses the write.
    always_ff @(posedge clk) begin
        if (reset_n && (w_gnt_a || w_gnt_b) && w_sel.wr && w_in_range)
            r_mem[w_idx] <= w_sel.data;
    end

    // Priority flips only when both channels were contending.
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_prio <= CHAN_A;
        else if (w_pend_a && w_pend_b)
            r_prio <= other_chan(r_prio);
    end

    // Response registers: one-cycle ack/err, dout updated only on read grants.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_err_a  <= 1'b0;
            r_err_b  <= 1'b0;
        end else begin
            r_ack_a <= w_gnt_a;
            r_ack_b <= w_gnt_b;
            r_err_a <= w_gnt_a && !w_in_range;
            r_err_b <= w_gnt_b && !w_in_range;
            if (w_gnt_a && !w_sel.wr)
                r_dout_a <= w_rdata;
            if (w_gnt_b && !w_sel.wr)
                r_dout_b <= w_rdata;
        end
    end

    assign o_dout_a = r_dout_a;
    assign o_dout_b = r_dout_b;
    assign o_ack_a  = r_ack_a;
    assign o_ack_b  = r_ack_b;
    assign o_err_a  = r_err_a;
    assign o_err_b  = r_err_b;

endmodule

// File: tb/tb_fisc_mem_responder.sv
// Self-checking bench for fisc_mem_responder against a transaction-level model.
module tb_fisc_mem_responder;

    localparam int DEPTH = 1024;
    localparam int OP_NONE = 0, OP_RD = 1, OP_WR = 2, OP_RDWR = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd_a = 0, wr_a = 0, rd_b = 0, wr_b = 0;
    logic [15:0] addr_a = 0, addr_b = 0;
    logic [63:0] din_a = 0, din_b = 0;
    logic [63:0] dout_a, dout_b;
    logic        ack_a, ack_b, err_a, err_b;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [63:0] mem_m [int];
    logic [63:0] dout_m [2];
    int          prio_m;

    always #5 clk = ~clk;

    fisc_mem_responder #(.DATA_W(64), .ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_rd_a   (rd_a),
        .i_wr_a   (wr_a),
        .i_addr_a (addr_a),
        .i_din_a  (din_a),
        .o_dout_a (dout_a),
        .o_ack_a  (ack_a),
        .o_err_a  (err_a),
        .i_rd_b   (rd_b),
        .i_wr_b   (wr_b),
        .i_addr_b (addr_b),
        .i_din_b  (din_b),
        .o_dout_b (dout_b),
        .o_ack_b  (ack_b),
        .o_err_b  (err_b)
    );

    // Drive one request per channel for a single cycle, then check the two
    // response cycles against the model's serialized order of accesses.
    task automatic run_pair(input string tag,
                            input int op_a, input logic [15:0] ad_a, input logic [63:0] dt_a,
                            input int op_b, input logic [15:0] ad_b, input logic [63:0] dt_b);
        int          ops [2];
        logic [15:0] ads [2];
        logic [63:0] dts [2];
        int          ord [2];
        int          n;
        logic [63:0] exp_dout [2][2];
        logic        exp_ack [2][2];
        logic        exp_err [2][2];
        logic [63:0] act_dout [2];
        logic        act_ack [2];
        logic        act_err [2];
        ops[0] = op_a; ads[0] = ad_a; dts[0] = dt_a;
        ops[1] = op_b; ads[1] = ad_b; dts[1] = dt_b;
        n = 0;
        ord[0] = 0; ord[1] = 1;
        if (op_a != OP_NONE && op_b != OP_NONE) begin
            ord[0] = prio_m; ord[1] = 1 - prio_m; n = 2;
            prio_m = 1 - prio_m;
        end else if (op_a != OP_NONE) begin
            ord[0] = 0; n = 1;
        end else if (op_b != OP_NONE) begin
            ord[0] = 1; n = 1;
        end
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
                exp_ack[k][c] = 1'b0;
                exp_err[k][c] = 1'b0;
            end
            if (k < n) begin
                int  ch;
                bit  inr;
                ch  = ord[k];
                inr = (int'(ads[ch]) < DEPTH);
                exp_ack[k][ch] = 1'b1;
                exp_err[k][ch] = !inr;
                if (ops[ch] >= OP_WR) begin
                    if (inr) mem_m[int'(ads[ch])] = dts[ch];
                end else begin
                    dout_m[ch] = inr ? mem_m[int'(ads[ch])] : 64'd0;
                end
            end
            for (int c = 0; c < 2; c++) exp_dout[k][c] = dout_m[c];
        end

        rd_a = (op_a == OP_RD) || (op_a == OP_RDWR);
        wr_a = (op_a >= OP_WR);
        addr_a = ad_a; din_a = dt_a;
        rd_b = (op_b == OP_RD) || (op_b == OP_RDWR);
        wr_b = (op_b >= OP_WR);
        addr_b = ad_b; din_b = dt_b;
        @(negedge clk);
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            act_dout[0] = dout_a; act_dout[1] = dout_b;
            act_ack[0]  = ack_a;  act_ack[1]  = ack_b;
            act_err[0]  = err_a;  act_err[1]  = err_b;
            for (int c = 0; c < 2; c++) begin
                n_chk++;
                if (act_ack[c] !== exp_ack[k][c])
                    $display("FAIL %s ack_%s cyc%0d: got %b want %b", tag, c ? "b" : "a", k, act_ack[c], exp_ack[k][c]);
                else n_pass++;
                n_chk++;
                if (act_err[c] !== exp_err[k][c])
                    $display("FAIL %s err_%s cyc%0d: got %b want %b", tag, c ? "b" : "a", k, act_err[c], exp_err[k][c]);
                else n_pass++;
                n_chk++;
                if (act_dout[c] !== exp_dout[k][c])
                    $display("FAIL %s dout_%s cyc%0d: got %h want %h", tag, c ? "b" : "a", k, act_dout[c], exp_dout[k][c]);
                else n_pass++;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_chk++;
        if ({ack_a, ack_b, err_a, err_b} !== 4'b0)
            $display("FAIL %s ack/err: got %b want 0000", tag, {ack_a, ack_b, err_a, err_b});
        else n_pass++;
        n_chk++;
        if (dout_a !== 64'd0) $display("FAIL %s dout_a: got %h want 0", tag, dout_a);
        else n_pass++;
        n_chk++;
        if (dout_b !== 64'd0) $display("FAIL %s dout_b: got %h want 0", tag, dout_b);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        prio_m = 0;
        dout_m[0] = 0; dout_m[1] = 0;
    endtask

    // Give every low address a known value so later reads are predictable.
    task automatic test_init();
        for (int i = 0; i < 16; i++)
            if (i % 2 == 0) run_pair("init", OP_WR, 16'(i), {32'hA000_0000, 32'(i)}, OP_NONE, 0, 0);
            else            run_pair("init", OP_NONE, 0, 0, OP_WR, 16'(i), {32'hB000_0000, 32'(i)});
    endtask

    task automatic test_basic();
        run_pair("basic_wr", OP_WR, 16'd5, 64'hDEAD_BEEF_0000_1234, OP_NONE, 0, 0);
        run_pair("basic_rd", OP_RD, 16'd5, 64'd0, OP_NONE, 0, 0);
    endtask

    task automatic test_conflict();
        run_pair("cf_setup", OP_NONE, 0, 0, OP_WR, 16'd7, 64'h22);
        run_pair("cf_a_first", OP_WR, 16'd7, 64'h11, OP_RD, 16'd7, 0);
        run_pair("cf_b_first", OP_WR, 16'd7, 64'h33, OP_RD, 16'd7, 0);
        run_pair("cf_rd_rd", OP_RD, 16'd7, 0, OP_RD, 16'd5, 0);
    endtask

    task automatic test_rdwr();
        run_pair("rdwr", OP_RDWR, 16'd3, 64'h55, OP_NONE, 0, 0);
        run_pair("rdwr_rd", OP_RD, 16'd3, 0, OP_NONE, 0, 0);
    endtask

    task automatic test_oor();
        run_pair("oor_rd", OP_NONE, 0, 0, OP_RD, 16'd1024, 0);
        run_pair("oor_wr", OP_WR, 16'd2000, 64'hFFFF_FFFF_FFFF_FFFF, OP_NONE, 0, 0);
        for (int i = 0; i < 16; i += 2)
            run_pair("oor_scan", OP_RD, 16'(i), 0, OP_RD, 16'(i + 1), 0);
    endtask

    task automatic test_reset_mid();
        rd_b = 0; wr_b = 1; addr_b = 16'd9; din_b = 64'h77;
        @(negedge clk);
        wr_b = 0;
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        reset_n = 1'b1;
        prio_m = 0;
        dout_m[0] = 0; dout_m[1] = 0;
        @(negedge clk);
        check_idle_outputs("rst_mid_after");
        run_pair("rst_mid_rd9", OP_NONE, 0, 0, OP_RD, 16'd9, 0);
    endtask

    task automatic test_held_read();
        int acks;
        acks = 0;
        rd_a = 1; addr_a = 16'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) acks++;
            n_chk++;
            if (ack_a !== ((i % 2) == 0))
                $display("FAIL held edge%0d ack_a: got %b want %b", i, ack_a, ((i % 2) == 0));
            else n_pass++;
        end
        rd_a = 0;
        n_chk++;
        if (acks != 5) $display("FAIL held ack count: got %0d want 5", acks);
        else n_pass++;
        dout_m[0] = mem_m[5];
        n_chk++;
        if (dout_a !== dout_m[0]) $display("FAIL held dout_a: got %h want %h", dout_a, dout_m[0]);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (ack_a !== 1'b0) $display("FAIL held tail ack_a: got %b want 0", ack_a);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int          oa, ob;
            logic [15:0] aa, ab;
            oa = $urandom_range(0, 3);
            ob = $urandom_range(0, 3);
            aa = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 15));
            ab = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 15));
            run_pair("rand", oa, aa, {$urandom, $urandom}, ob, ab, {$urandom, $urandom});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init();
        test_basic();
        test_conflict();
        test_rdwr();
        test_oor();
        test_reset_mid();
        test_held_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fisc_mem_responder.md
# fisc_mem_responder

Dual-channel memory responder that serves the core's two memory channels (a, b). It captures read/write requests from each channel and arbitrates them onto one shared single-port word array, one access per cycle. It returns read data and a one-cycle acknowledge per completed access. It sits between the FISC core's address/data buses and on-chip boot/program RAM.

## Interface
Parameters:
- DATA_W, 64: word width; equals the core's integer size.
- ADDR_W, 16: address bus width; equals the core's boot address size.
- DEPTH, 1024: number of words in the array; valid addresses are 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rd_a / rd_b  in  1  read request level, per channel.
- wr_a / wr_b  in  1  write request level, per channel.
- addr_a / addr_b  in  ADDR_W  word address, per channel.
- din_a / din_b  in  DATA_W  write data from the core's dout bus.
- dout_a / dout_b  out  DATA_W  read data to the core's din bus.
- ack_a / ack_b  out  1  one-cycle pulse when the channel's access completes.
- err_a / err_b  out  1  one-cycle pulse with ack when the address was >= DEPTH.

## Operation
- Reset is decided as: reset reset_n, synchronous, active-low; clock clk.
- Per-channel FSM with two states:
  - CH_IDLE: on an edge with rd_x|wr_x high, latch {wr_x, addr_x, din_x} and go to CH_PEND.
  - CH_PEND: wait for grant. On grant, perform the access, pulse ack_x and return to CH_IDLE.
- While a channel is in CH_PEND, its inputs are ignored.
- Requests are level-sensitive. A request still held after ack is captured again on the next edge, so a held request is re-executed. This is harmless for reads and idempotent for writes.
- rd_x and wr_x both high: treated as a write; rd is ignored.
- Arbiter:
  - If exactly one channel is pending, it is granted.
  - If both are pending, the channel named by the priority flag prio is granted; prio then flips to the other channel.
  - prio resets to channel a.
  - An uncontested grant does not change prio.
- Write grant: mem[addr] <= data. dout_x holds its previous value.
- Read grant: dout_x <= mem[addr]. dout_x holds until the next read grant on that channel.
- Address >= DEPTH: a write is dropped; a read returns 0. err_x pulses together with ack_x.
- Write on one channel and read on the other, same address: accesses are serialized by the arbiter. The read sees the new value only if the write was granted first.

## Timing
- Reset values: dout_a = dout_b = 0, ack_* = 0, err_* = 0, both channels CH_IDLE, prio = a.
- Array contents are not reset.
- Uncontested latency: request captured at edge N; access, ack and dout are valid after edge N+1 (two edges from request to ack).
- Losing a conflict adds exactly one cycle; the loser is granted at edge N+2.
- Repeated access with a request held continuously: capture at N, ack at N+1, capture at N+2, ack at N+3. One access per channel every 2 cycles.
- Aggregate throughput: at most one array access per cycle.
- ack_x and err_x are high for exactly one cycle per access.
- Reset mid-operation:
  - reset_n low wins over any grant on that edge, so no write is performed.
  - Pending requests are discarded and no ack is issued.
- Read-during-write hazard cannot occur; there is a single access per cycle.

## Structure
- Shared package fisc_mem_pkg holds:
  - typedef mem_req_t {logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}
  - enum ch_state_t {CH_IDLE, CH_PEND}
  - enum chan_t {CHAN_A, CHAN_B}
- Sub-module fisc_mem_req_port: the per-channel capture FSM plus its mem_req_t register. It is instantiated twice.
- Top level holds the arbiter, prio, the array (inferred RAM), and the dout/ack/err registers.

## Test plan
- Reset, then wr_a=1 with addr_a=5, din_a=0xDEAD_BEEF_0000_1234 for 1 cycle; then rd_a with addr_a=5 -> ack_a one edge after each capture; dout_a=0xDEAD_BEEF_0000_1234; err_a=0.
- Same edge: wr_a addr 7 data 0x11 and rd_b addr 7 (old value 0x22) -> A granted first; ack_b one cycle later with dout_b=0x11; prio=b. Repeat the conflict -> B granted first.
- rd_a=wr_a=1, addr 3, din 0x55 -> write performed; dout_a unchanged; a subsequent read of addr 3 returns 0x55.
- rd_b at addr DEPTH (1024) -> ack_b and err_b pulse together; dout_b=0. A write to addr 2000 leaves all in-range contents unchanged.
- Capture wr_b addr 9 data 0x77 (pending), then assert reset_n=0 on the grant edge -> no ack_b; mem[9] keeps its old value; all outputs at reset values.
- Hold rd_a high for 10 cycles, no b traffic -> exactly 5 ack_a pulses, on alternate cycles.
